histogram_stream: RTL and testbench

// - Parametrised pixel-intensity histogram for the star-tracker frame path; sits after the pixel stream, before threshold selection.
// - Accumulates one frame (ended by s_last) into a RAM of 2^BIN_W saturating counters.
// - Streams bins out serially with valid/ready, clearing each bin as it is read.
// - Pipelined read-modify-write with forwarding; accepts one pixel per cycle, no bubbles.

---
 rtl/histogram_stream.sv | 189 ++++++++++++++++++
 tb/tb_histogram_stream.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histogram_stream.sv
// -----------------------------------------------------------------------------
// histogram_stream
//   Pixel-intensity histogram for the star-tracker frame path. Each accepted
//   pixel increments a saturating counter selected by its top BIN_W bits. When
//   a frame ends (s_last), the 2^BIN_W bins are streamed out in order over a
//   valid/ready port. Each bin is zeroed as it is read, so the next frame needs
//   no separate clear pass. A full clear pass runs only after reset.
//
//   Increment path: stage p1 reads the counter RAM, and stage p2 writes back
//   the saturated increment. The p2 result is forwarded into p1 when both
//   stages hold the same bin. This lets the block take one pixel per cycle.
//
// Ports
//   i_clk, i_reset       clock; synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   pixel input stream
//   m_valid/m_bin/m_count/m_last/m_ready   bin output stream
//   m_cdf                running sum of m_count up to and including m_bin
//                        (present only when HIST_CDF_EN is defined)
//   o_busy               high while clearing, draining or reading out
//   o_overflow           sticky: some bin saturated during the current frame
//
// Build option: define HIST_CDF_EN to add the m_cdf output and its accumulator.
// -----------------------------------------------------------------------------
module histogram_stream #(
  parameter int DATA_W = 8,
  parameter int BIN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              m_valid,
  output logic [BIN_W-1:0]  m_bin,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_last,
  input  logic              m_ready,
`ifdef HIST_CDF_EN
  output logic [CNT_W+BIN_W-1:0] m_cdf,
`endif
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int               NBINS     = 1 << BIN_W;
  localparam logic [BIN_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_READ} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_mem [NBINS];
  logic [BIN_W-1:0] r_addr;
  logic             r_ovf;

  logic             r_vld_p1, r_vld_p2;
  logic [BIN_W-1:0] r_bin_p1, r_bin_p2;
  logic [CNT_W-1:0] r_cnt_p2;

  logic             w_accept, w_hs, w_fwd;
  logic [CNT_W-1:0] w_rd_p1, w_inc_p2;
  logic             w_unused_pix;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic is_sat(input logic [CNT_W-1:0] v);
    return v == CNT_MAX;
  endfunction

  // Pixel bits below the bin index carry no histogram information.
  assign w_unused_pix = ^s_data;

  assign w_accept = s_valid & s_ready;
  assign w_hs     = m_valid & m_ready;

  // Stage p2 computes the value written this cycle. When p1 holds the same bin,
  // it must use that value, because the RAM still holds the old count.
  assign w_inc_p2 = sat_inc(r_cnt_p2);
  assign w_fwd    = r_vld_p2 && (r_bin_p2 == r_bin_p1);
  assign w_rd_p1  = w_fwd ? w_inc_p2 : r_mem[r_bin_p1];

  // ---- stage p0 -> p1: capture accepted pixel's bin ----
  always_ff @(posedge i_clk) begin
    r_bin_p1 <= s_data[DATA_W-1 -: BIN_W];
  end

  // ---- stage p1 -> p2: RAM read (with forwarding) ----
  always_ff @(posedge i_clk) begin
    r_bin_p2 <= r_bin_p1;
    r_cnt_p2 <= w_rd_p1;
  end

  // ---- stage p2: write back saturated count ----
  // The three writers are mutually exclusive by state. In order, they are the
  // clear pass, the accumulate pipeline and the clear-on-read.
  always_ff @(posedge i_clk) begin
    if (r_state == S_CLEAR)
      r_mem[r_addr] <= '0;
    else if (r_vld_p2)
      r_mem[r_bin_p2] <= w_inc_p2;
    else if (w_hs)
      r_mem[r_addr] <= '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_addr   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      // One address counter serves both the clear pass and the readout. It
      // wraps to 0 after the last bin, ready for the next use.
      if (r_state == S_CLEAR || w_hs)
        r_addr <= r_addr + 1'b1;
      if (w_hs && m_last)
        r_ovf <= 1'b0;
      else if (r_vld_p2 && is_sat(r_cnt_p2))
        r_ovf <= 1'b1;
    end
  end

`ifdef HIST_CDF_EN
  logic [CNT_W+BIN_W-1:0] r_cdf;
  logic [CNT_W+BIN_W-1:0] w_cnt_ext;

  assign w_cnt_ext = {{BIN_W{1'b0}}, m_count};
  assign m_cdf     = r_cdf + w_cnt_ext;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_cdf <= '0;
    else if (w_hs)
      r_cdf <= m_last ? '0 : m_cdf;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_CLEAR;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    o_busy      = 1'b1;
    m_valid     = 1'b0;
    m_bin       = '0;
    m_count     = '0;
    m_last      = 1'b0;
    case (r_state)
      S_CLEAR: begin
        if (r_addr == LAST_ADDR)
          w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        s_ready = 1'b1;
        o_busy  = 1'b0;
        if (s_valid && s_last)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The last pixel leaves p1 here. Its write-back lands on the same edge
        // that enters S_READ, so bin 0 is already up to date when it is shown.
        if (!r_vld_p1)
          w_state_nxt = S_READ;
      end
      S_READ: begin
        m_valid = 1'b1;
        m_bin   = r_addr;
        m_count = r_mem[r_addr];
        m_last  = (r_addr == LAST_ADDR);
        if (m_ready && m_last)
          w_state_nxt = S_ACCUM;
      end
    endcase
  end

  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_histogram_stream.sv
// -----------------------------------------------------------------------------
// tb_histogram_stream
//   Self-checking bench for histogram_stream with DATA_W=8, BIN_W=4, CNT_W=4.
//   Frames are driven pixel by pixel into a reference histogram. When the last
//   pixel is sent, the expected bins are pushed to a scoreboard queue. During
//   readout the bench pops that queue and compares it with the DUT output.
//   Define HIST_CDF_EN to also check m_cdf.
// -----------------------------------------------------------------------------
module tb_histogram_stream;
  localparam int DATA_W = 8;
  localparam int BIN_W  = 4;
  localparam int CNT_W  = 4;
  localparam int NB     = 16;
  localparam int CMAX   = 15;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              m_valid;
  logic [BIN_W-1:0]  m_bin;
  logic [CNT_W-1:0]  m_count;
  logic              m_last;
  logic              m_ready;
  logic              o_busy;
  logic              o_overflow;
`ifdef HIST_CDF_EN
  logic [CNT_W+BIN_W-1:0] m_cdf;
`endif

  histogram_stream #(.DATA_W(DATA_W), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_bin      (m_bin),
    .m_count    (m_count),
    .m_last     (m_last),
    .m_ready    (m_ready),
`ifdef HIST_CDF_EN
    .m_cdf      (m_cdf),
`endif
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int bin;
    int cnt;
    int last;
    int cdf;
  } exp_t;

  typedef logic [7:0] pix_q_t[$];

  exp_t sb[$];
  int   model[NB];
  bit   model_ovf;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) model[i] = 0;
    model_ovf = 1'b0;
  endtask

  // Reset, optionally check reset values, then measure the clear pass length.
  task automatic do_reset(input bit check_vals);
    int n;
    i_reset = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", o_busy, 1);
    if (check_vals) begin
      chk("rst_m_bin", m_bin, 0);
      chk("rst_m_count", m_count, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_ovf", o_overflow, 0);
    end
    tick();
    i_reset = 1'b0;
    n = 0;
    while (!s_ready && n < 40) begin
      tick();
      n++;
    end
    chk("clear_len", n, 16);
    chk("busy_fall", o_busy, 0);
    sb.delete();
    model_clear();
  endtask

  task automatic send_frame(input pix_q_t px);
    int n;
    int b;
    int sum;
    exp_t e;
    for (int i = 0; i < px.size(); i++) begin
      s_valid = 1'b1;
      s_data  = px[i];
      s_last  = (i == px.size() - 1);
      chk("s_ready_accum", s_ready, 1);
      b = int'(px[i] >> 4);
      if (model[b] == CMAX) model_ovf = 1'b1;
      else model[b]++;
      tick();
    end
    // Junk pixels while draining must be ignored.
    s_valid = 1'b1;
    s_data  = 8'h00;
    s_last  = 1'b1;
    chk("s_ready_drop", s_ready, 0);
    n = 0;
    while (!m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("latency", n, 2);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("ovf_frame", o_overflow, model_ovf);
    sum = 0;
    for (int i = 0; i < NB; i++) begin
      sum += model[i];
      e.bin  = i;
      e.cnt  = model[i];
      e.last = (i == NB - 1);
      e.cdf  = sum;
      sb.push_back(e);
    end
  endtask

  // Read up to max_bins bins using the given m_ready pattern.
  task automatic readout(input bit stall, input int max_bins);
    bit   pat[4];
    int   got;
    int   cyc;
    int   k;
    bit   stalled;
    int   pbin;
    int   pcnt;
    int   plast;
    exp_t e;
    pat = stall ? '{1'b1, 1'b0, 1'b0, 1'b1} : '{1'b1, 1'b1, 1'b1, 1'b1};
    got = 0;
    cyc = 0;
    k = 0;
    stalled = 1'b0;
    pbin = 0;
    pcnt = 0;
    plast = 0;
    while (got < max_bins && cyc < 200) begin
      m_ready = pat[k % 4];
      k++;
      // Pixels offered during readout must be ignored; stop at the last bin.
      s_valid = !m_last;
      s_data  = 8'h00;
      if (stalled) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_bin", m_bin, pbin);
        chk("hold_cnt", m_count, pcnt);
        chk("hold_last", m_last, plast);
      end
      if (!m_valid) begin
        chk("rd_valid", m_valid, 1);
        stalled = 1'b0;
      end else if (m_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("bin", m_bin, e.bin);
          chk("count", m_count, e.cnt);
          chk("last", m_last, e.last);
`ifdef HIST_CDF_EN
          chk("cdf", m_cdf, e.cdf);
`endif
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pbin = m_bin;
        pcnt = m_count;
        plast = m_last;
      end
      tick();
      cyc++;
    end
    if (got < max_bins) chk("readout_timeout", got, max_bins);
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (max_bins == NB) begin
      chk("end_m_valid", m_valid, 0);
      chk("end_ovf", o_overflow, 0);
      chk("end_s_ready", s_ready, 1);
      model_clear();
    end
  endtask

  initial begin
    pix_q_t f;
    n_tests = 0;
    n_fail  = 0;
    i_reset = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    do_reset(1'b1);

    // Basic frame with back-to-back same-bin pixels.
    f = '{8'h00, 8'h10, 8'h1F, 8'hF0};
    send_frame(f);
    readout(1'b0, NB);

    // Saturation of bin 5, read with stalls.
    f.delete();
    for (int i = 0; i < 20; i++) f.push_back(8'h55);
    send_frame(f);
    chk("ovf_set", o_overflow, 1);
    readout(1'b1, NB);

    // Random frame: also exposes residue from the previous frame.
    f.delete();
    for (int i = 0; i < 40; i++) f.push_back(8'($urandom_range(0, 255)));
    send_frame(f);
    readout(1'b1, NB);

    // One-pixel frame.
    f = '{8'hF7};
    send_frame(f);
    readout(1'b0, NB);

    // Reset in the middle of readout, then a fresh frame must show no residue.
    f = '{8'h90, 8'h91, 8'h92, 8'hE0, 8'hE1, 8'h20};
    send_frame(f);
    readout(1'b0, 5);
    do_reset(1'b0);
    f = '{8'h20};
    send_frame(f);
    readout(1'b1, NB);

`ifdef HIST_CDF_EN
    f.delete();
    for (int i = 0; i < 8; i++) f.push_back(8'h30);
    send_frame(f);
    readout(1'b0, NB);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
